// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the four inputs of the shared 4:1 mux.
// It registers a one-hot grant and the matching mux select, and limits how long one owner can hold the grant.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       grant_r, grant_s;
  logic [1:0]       sel_r, sel_s;
  logic [1:0]       last_r, last_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic             busy_r, busy_s;

  logic [3:0]       others_s;
  logic [3:0]       cand_s;
  logic [2:0]       pick_s;
  logic             found_s;
  logic [1:0]       win_s;

  // Returns {found, index}. The first set bit of r is searched for from start, wrapping around.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // When the arbiter is in GRANT, last_r is the current owner, so one search can serve both states.
  assign others_s = req & ~(4'b0001 << last_r);
  assign cand_s   = (state_r == GRANT) ? others_s : req;
  assign pick_s   = rr_pick(cand_s, last_r + 2'd1);
  assign found_s  = pick_s[2];
  assign win_s    = pick_s[1:0];

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant_r    <= 4'b0000;
      sel_r      <= 2'b00;
      last_r     <= 2'd3;
      hold_cnt_r <= '0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      sel_r      <= sel_s;
      last_r     <= last_s;
      hold_cnt_r <= hold_cnt_s;
      busy_r     <= busy_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!req[last_r] && !found_s) begin
          state_s = IDLE;
        end else begin
          state_s = GRANT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs. sel keeps its old value when the arbiter drops to idle.
  always_comb begin
    grant_s    = grant_r;
    sel_s      = sel_r;
    last_s     = last_r;
    hold_cnt_s = hold_cnt_r;
    busy_s     = busy_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_s    = 4'b0001 << win_s;
          sel_s      = win_s;
          last_s     = win_s;
          hold_cnt_s = CNT_W'(1);
          busy_s     = 1'b1;
        end else begin
          grant_s    = 4'b0000;
          hold_cnt_s = '0;
          busy_s     = 1'b0;
        end
      end
      GRANT: begin
        if (!req[last_r] || (hold_cnt_r >= CNT_W'(MAX_HOLD))) begin
          if (found_s) begin
            grant_s    = 4'b0001 << win_s;
            sel_s      = win_s;
            last_s     = win_s;
            hold_cnt_s = CNT_W'(1);
            busy_s     = 1'b1;
          end else if (!req[last_r]) begin
            grant_s    = 4'b0000;
            hold_cnt_s = '0;
            busy_s     = 1'b0;
          end else begin
            // The owner is alone and may keep the grant; the counter stays at the limit.
            hold_cnt_s = CNT_W'(MAX_HOLD);
          end
        end else begin
          hold_cnt_s = hold_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        grant_s    = 4'b0000;
        sel_s      = 2'b00;
        last_s     = 2'd3;
        hold_cnt_s = '0;
        busy_s     = 1'b0;
      end
    endcase
  end

  assign grant = grant_r;
  assign sel   = sel_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter. For each cycle of stimulus, a queue-based reference model
// pushes the expected outputs, and an independent monitor pops them and compares.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int BOUND    = 3 * MAX_HOLD + 1;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  logic       clk = 1'b1;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Reference model state: the owner index (-1 when idle), the hold count, the last winner and sel.
  int m_owner, m_hold, m_last, m_sel;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .grant(grant),
    .sel  (sel),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int last, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rn);
    int w;
    if (!rn) begin
      m_owner = -1; m_hold = 0; m_last = 3; m_sel = 0;
    end else if (m_owner < 0) begin
      w = pick(r, m_last, -1);
      if (w >= 0) begin m_owner = w; m_last = w; m_sel = w; m_hold = 1; end
    end else if (!r[m_owner]) begin
      w = pick(r, m_last, m_owner);
      if (w >= 0) begin m_owner = w; m_last = w; m_sel = w; m_hold = 1; end
      else begin m_owner = -1; m_hold = 0; end
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end else begin
      w = pick(r, m_last, m_owner);
      if (w >= 0) begin m_owner = w; m_last = w; m_sel = w; m_hold = 1; end
      else m_hold = MAX_HOLD;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rn);
    exp_t e;
    @(negedge clk);
    req   = r;
    rst_n = rn;
    model_step(r, rn);
    e.g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.s = 2'(m_sel);
    e.b = (m_owner >= 0);
    exp_q.push_back(e);
  endtask

  task automatic repeat_step(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b1);
  endtask

  // Monitor: pops an expected entry after each rising edge and also checks the invariants and fairness.
  initial begin : monitor
    exp_t e;
    int wait_cnt[4];
    logic inv_ok;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.g || sel !== e.s || busy !== e.b) begin
          errors++;
          $display("FAIL scoreboard t=%0t req=%b: got grant=%b sel=%b busy=%b, want grant=%b sel=%b busy=%b",
                   $time, req, grant, sel, busy, e.g, e.s, e.b);
        end
        inv_ok = $onehot0(grant) && (busy === |grant) &&
                 (!busy || (grant === (4'b0001 << sel)));
        checks++;
        if (!inv_ok) begin
          errors++;
          $display("FAIL invariant t=%0t: got grant=%b sel=%b busy=%b, want onehot0 grant matching sel/busy",
                   $time, grant, sel, busy);
        end
        for (int i = 0; i < 4; i++) begin
          if (!rst_n || !req[i] || grant[i]) wait_cnt[i] = 0;
          else wait_cnt[i]++;
          if (wait_cnt[i] == BOUND + 1) begin
            checks++;
            errors++;
            $display("FAIL fairness t=%0t: requester %0d waited %0d cycles, want at most %0d",
                     $time, i, wait_cnt[i], BOUND);
          end
        end
      end
    end
  end

  initial begin : driver
    logic [3:0] r;
    logic       rn;
    rst_n = 1'b0;
    req   = 4'b0000;
    m_owner = -1; m_hold = 0; m_last = 3; m_sel = 0;

    // Reset held with all requests set, then preemption rotation under full contention
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    repeat_step(4'b1111, 18);

    // Single requester that is held and then released
    step(4'b0000, 1'b0);
    repeat_step(4'b0100, 6);
    repeat_step(4'b0000, 3);

    // Early-release handover from owner 1 to owner 3, then to owner 0
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b1011, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);

    // Wrap after reset: requester 0 is served before requester 3
    step(4'b0000, 1'b0);
    step(4'b1001, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);

    // Reset in the middle of a grant, then the hold count must restart
    step(4'b0000, 1'b0);
    repeat_step(4'b0100, 2);
    step(4'b0100, 1'b0);
    repeat_step(4'b0100, 2);
    repeat_step(4'b1100, 10);

    // Randomised traffic with sticky requests and an occasional reset
    r = 4'b1111;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      rn = ($urandom_range(299) != 0);
      step(r, rn);
    end

    // Allow the monitor to drain the queue, but only for a bounded time
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
